vram_blit_arbiter: RTL

Hardware blitter and VRAM write-port arbiter between the CPU bus and the frame buffer's write port. The CPU queues a rectangle copy from a picture ROM (bird, wall, start screen, pre-muxed into one source port) to screen coordinates. The block streams pixels into VRAM while still letting direct CPU VRAM writes through with absolute priority. It replaces the direct bus-to-VRAM write connection and offloads the per-pixel copy loops from the MIPS core.

---
 rtl/vram_pkg.sv | 17 +
 rtl/blit_addr_gen.sv | 94 +++++++++
 rtl/vram_blit_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM blitter/arbiter: FSM encoding, screen geometry,
// pixel width and the default transparent key colour.
package vram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } blit_state_t;

  localparam int SCREEN_W_DEF = 512;
  localparam int SCREEN_H_DEF = 480;
  localparam int PIX_W        = 12;
  localparam logic [PIX_W-1:0] KEY_COLOR_DEF = 12'hF0F;

endpackage

// File: rtl/blit_addr_gen.sv
// Pixel walker for one blit: col/row counters, source pointer, destination
// pointer, clip flags and last-pixel flag, all advanced incrementally.
module blit_addr_gen
  import vram_pkg::*;
#(
  parameter int SRC_AW   = 17,
  parameter int VRAM_AW  = 18,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_advance,
  input  logic [SRC_AW-1:0]  i_src_base,
  input  logic [9:0]         i_w,
  input  logic [8:0]         i_h,
  input  logic [9:0]         i_x,
  input  logic [8:0]         i_y,
  output logic [SRC_AW-1:0]  o_src_addr,
  output logic [VRAM_AW-1:0] o_dst_addr,
  output logic               o_clip,
  output logic               o_last
);

  logic [9:0]         r_w;
  logic [8:0]         r_h;
  logic [9:0]         r_x;
  logic [9:0]         r_col;
  logic [8:0]         r_row;
  logic [SRC_AW-1:0]  r_src_ptr;
  logic [VRAM_AW-1:0] r_dst_row;
  logic [VRAM_AW-1:0] r_dst_ptr;
  logic [10:0]        r_xs;
  logic [9:0]         r_ys;

  logic               w_col_end;
  logic               w_row_end;
  logic [VRAM_AW-1:0] w_dst_start;
  logic [VRAM_AW-1:0] w_dst_next_row;

  assign w_col_end      = (r_col == (r_w - 10'd1));
  assign w_row_end      = (r_row == (r_h - 9'd1));
  // The only multiply happens once per command, never per pixel.
  assign w_dst_start    = VRAM_AW'(i_y) * VRAM_AW'(SCREEN_W) + VRAM_AW'(i_x);
  assign w_dst_next_row = r_dst_row + VRAM_AW'(SCREEN_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w       <= '0;
      r_h       <= '0;
      r_x       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_src_ptr <= '0;
      r_dst_row <= '0;
      r_dst_ptr <= '0;
      r_xs      <= '0;
      r_ys      <= '0;
    end else if (i_start) begin
      r_w       <= i_w;
      r_h       <= i_h;
      r_x       <= i_x;
      r_col     <= '0;
      r_row     <= '0;
      r_src_ptr <= i_src_base;
      r_dst_row <= w_dst_start;
      r_dst_ptr <= w_dst_start;
      r_xs      <= {1'b0, i_x};
      r_ys      <= {1'b0, i_y};
    end else if (i_advance) begin
      r_src_ptr <= r_src_ptr + 1'b1;
      if (w_col_end) begin
        r_col     <= '0;
        r_row     <= r_row + 9'd1;
        r_dst_row <= w_dst_next_row;
        r_dst_ptr <= w_dst_next_row;
        r_xs      <= {1'b0, r_x};
        r_ys      <= r_ys + 10'd1;
      end else begin
        r_col     <= r_col + 10'd1;
        r_dst_ptr <= r_dst_ptr + 1'b1;
        r_xs      <= r_xs + 11'd1;
      end
    end
  end

  assign o_src_addr = r_src_ptr;
  assign o_dst_addr = r_dst_ptr;
  // Sums are one bit wider than the coordinates, so the compare cannot wrap.
  assign o_clip     = (r_xs >= 11'(SCREEN_W)) || (r_ys >= 10'(SCREEN_H));
  assign o_last     = w_col_end && w_row_end;

endmodule

// File: rtl/vram_blit_arbiter.sv
// Rectangle blitter from picture ROM to VRAM with absolute-priority CPU writes.
// Optional BLIT_TRANSPARENT_EN: source pixels equal to KEY_COLOR are skipped.
module vram_blit_arbiter
  import vram_pkg::*;
#(
  parameter int SRC_AW   = 17,
  parameter int VRAM_AW  = 18,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter logic [PIX_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SRC_AW-1:0]  cmd_src_base,
  input  logic [9:0]         cmd_w,
  input  logic [8:0]         cmd_h,
  input  logic [9:0]         cmd_x,
  input  logic [8:0]         cmd_y,
  output logic               busy,
  output logic               done,
  output logic [SRC_AW-1:0]  src_addr,
  input  logic [PIX_W-1:0]   src_data,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [PIX_W-1:0]   cpu_data,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [PIX_W-1:0]   vram_data
);

  // Command handshake: a command transfers on a cycle with cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so cmd_* are ignored while busy.
  blit_state_t        r_state;
  blit_state_t        w_next;
  logic               w_start;
  logic               w_advance;
  logic               w_empty;
  logic               w_clip;
  logic               w_last;
  logic               w_key;
  logic               w_blit_we;
  logic [VRAM_AW-1:0] w_dst_addr;

  assign w_start   = (r_state == ST_IDLE) && cmd_valid;
  assign w_advance = (r_state == ST_WRITE) && !cpu_we;
  assign w_empty   = (cmd_w == 10'd0) || (cmd_h == 9'd0);

`ifdef BLIT_TRANSPARENT_EN
  assign w_key = (src_data == KEY_COLOR);
`else
  logic w_unused_key;
  assign w_unused_key = ^KEY_COLOR;
  assign w_key        = 1'b0;
`endif

  blit_addr_gen #(
    .SRC_AW   (SRC_AW),
    .VRAM_AW  (VRAM_AW),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_advance  (w_advance),
    .i_src_base (cmd_src_base),
    .i_w        (cmd_w),
    .i_h        (cmd_h),
    .i_x        (cmd_x),
    .i_y        (cmd_y),
    .o_src_addr (src_addr),
    .o_dst_addr (w_dst_addr),
    .o_clip     (w_clip),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_next = w_empty ? ST_FIN : ST_FETCH;
      ST_FETCH: w_next = ST_WRITE;
      ST_WRITE: if (!cpu_we) w_next = w_last ? ST_FIN : ST_FETCH;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // A clipped or transparent pixel still spends its WRITE slot, it just writes nothing.
  assign w_blit_we = (r_state == ST_WRITE) && !cpu_we && !w_clip && !w_key;

  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_FIN);
    vram_we   = 1'b0;
    vram_addr = '0;
    vram_data = '0;
    if (cpu_we) begin
      vram_we   = 1'b1;
      vram_addr = cpu_addr;
      vram_data = cpu_data;
    end else if (w_blit_we) begin
      vram_we   = 1'b1;
      vram_addr = w_dst_addr;
      vram_data = src_data;
    end
  end

endmodule
